// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage load/store unit of a 32-bit RISC-V pipeline.
// Takes the ALU result as the effective address. It drives a single-outstanding
// req/gnt/rvalid data-memory port, builds byte enables and replicated store
// lanes, and extends load data. It also reports misaligned accesses and bus
// timeouts, and stalls upstream stages while an access is in flight.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   ex_*                       execute-stage request (valid, load/store, funct3,
//                              addr, wdata, rd)
//   lsu_stall                  hold upstream stages (combinational)
//   dmem_req/we/addr/be/wdata  registered memory request
//   dmem_gnt/rvalid/rdata      memory grant and response
//   mem_done                   one-cycle completion pulse
//   wb_we/wb_rd/wb_data        load write-back
//   misaligned/_addr           misaligned-access pulse and faulting address
//   bus_err                    one-cycle timeout pulse
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        ex_load,
  input  logic        ex_store,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  output logic        lsu_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        mem_done,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misaligned,
  output logic [31:0] misaligned_addr,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  addr_lo_q, addr_lo_d;   // only the byte offset is needed after accept
  logic [2:0]  funct3_q, funct3_d;
  logic [4:0]  rd_q, rd_d;
  logic        is_load_q, is_load_d;
  logic        dmem_req_q, dmem_req_d;
  logic        dmem_we_q, dmem_we_d;
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic [3:0]  dmem_be_q, dmem_be_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;
  logic        mem_done_q, mem_done_d;
  logic        wb_we_q, wb_we_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        misaligned_q, misaligned_d;
  logic [31:0] misaligned_addr_q, misaligned_addr_d;
  logic        bus_err_q, bus_err_d;

  logic        f3_legal_s, aligned_s, req_ok_s, accept_s, misalign_s, tmo_last_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_s, load_shift_s, load_ext_s;

  // Decode the execute-stage request: legality, alignment, lanes.
  always_comb begin
    f3_legal_s = 1'b0;
    aligned_s  = 1'b0;
    be_s       = 4'b0000;
    wdata_s    = 32'h0000_0000;
    case (ex_funct3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal_s = 1'b1;
      default:                                f3_legal_s = 1'b0;
    endcase
    // funct3[1:0] carries the access size for both signed and unsigned forms
    case (ex_funct3[1:0])
      2'b00: begin
        aligned_s = 1'b1;
        be_s      = 4'b0001 << ex_addr[1:0];
        wdata_s   = {4{ex_wdata[7:0]}};
      end
      2'b01: begin
        aligned_s = ~ex_addr[0];
        be_s      = 4'b0011 << ex_addr[1:0];
        wdata_s   = {2{ex_wdata[15:0]}};
      end
      2'b10: begin
        aligned_s = (ex_addr[1:0] == 2'b00);
        be_s      = 4'b1111;
        wdata_s   = ex_wdata;
      end
      default: begin
        aligned_s = 1'b0;
        be_s      = 4'b0000;
        wdata_s   = 32'h0000_0000;
      end
    endcase
    req_ok_s   = (state_q == ST_IDLE) & ex_valid & (ex_load ^ ex_store) & f3_legal_s;
    accept_s   = req_ok_s & aligned_s;
    misalign_s = req_ok_s & ~aligned_s;
  end

  // Extract and extend the addressed field of the returned read word.
  always_comb begin
    load_shift_s = dmem_rdata >> {addr_lo_q, 3'b000};
    case (funct3_q)
      3'b000:  load_ext_s = {{24{load_shift_s[7]}}, load_shift_s[7:0]};
      3'b001:  load_ext_s = {{16{load_shift_s[15]}}, load_shift_s[15:0]};
      3'b100:  load_ext_s = {24'h00_0000, load_shift_s[7:0]};
      3'b101:  load_ext_s = {16'h0000, load_shift_s[15:0]};
      default: load_ext_s = load_shift_s;
    endcase
  end

  assign tmo_last_s = (cnt_q == 8'(TIMEOUT_CYCLES - 1));

  // FSM next state, timeout counter and next values of all registered outputs.
  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    addr_lo_d         = addr_lo_q;
    funct3_d          = funct3_q;
    rd_d              = rd_q;
    is_load_d         = is_load_q;
    dmem_req_d        = dmem_req_q;
    dmem_we_d         = dmem_we_q;
    dmem_addr_d       = dmem_addr_q;
    dmem_be_d         = dmem_be_q;
    dmem_wdata_d      = dmem_wdata_q;
    mem_done_d        = 1'b0;
    wb_we_d           = 1'b0;
    wb_rd_d           = wb_rd_q;
    wb_data_d         = wb_data_q;
    misaligned_d      = 1'b0;
    misaligned_addr_d = misaligned_addr_q;
    bus_err_d         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d      = ST_REQ;
          cnt_d        = 8'd0;
          addr_lo_d    = ex_addr[1:0];
          funct3_d     = ex_funct3;
          rd_d         = ex_rd;
          is_load_d    = ex_load;
          dmem_req_d   = 1'b1;
          dmem_we_d    = ex_store;
          dmem_addr_d  = {ex_addr[31:2], 2'b00};
          dmem_be_d    = be_s;
          dmem_wdata_d = wdata_s;
        end else if (misalign_s) begin
          misaligned_d      = 1'b1;
          misaligned_addr_d = ex_addr;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (dmem_gnt) begin
          dmem_req_d = 1'b0;
          cnt_d      = 8'd0;
          if (is_load_q) begin
            state_d = ST_RESP;
          end else begin
            state_d    = ST_IDLE;
            mem_done_d = 1'b1;
          end
        end else if (tmo_last_s) begin
          dmem_req_d = 1'b0;
          state_d    = ST_IDLE;
          bus_err_d  = 1'b1;
          mem_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RESP: begin
        if (dmem_rvalid) begin
          state_d    = ST_IDLE;
          wb_data_d  = load_ext_s;
          wb_rd_d    = rd_q;
          wb_we_d    = 1'b1;
          mem_done_d = 1'b1;
        end else if (tmo_last_s) begin
          state_d    = ST_IDLE;
          bus_err_d  = 1'b1;
          mem_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        dmem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q           <= ST_IDLE;
      cnt_q             <= 8'd0;
      addr_lo_q         <= 2'b00;
      funct3_q          <= 3'b000;
      rd_q              <= 5'd0;
      is_load_q         <= 1'b0;
      dmem_req_q        <= 1'b0;
      dmem_we_q         <= 1'b0;
      dmem_addr_q       <= 32'h0000_0000;
      dmem_be_q         <= 4'b0000;
      dmem_wdata_q      <= 32'h0000_0000;
      mem_done_q        <= 1'b0;
      wb_we_q           <= 1'b0;
      wb_rd_q           <= 5'd0;
      wb_data_q         <= 32'h0000_0000;
      misaligned_q      <= 1'b0;
      misaligned_addr_q <= 32'h0000_0000;
      bus_err_q         <= 1'b0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      addr_lo_q         <= addr_lo_d;
      funct3_q          <= funct3_d;
      rd_q              <= rd_d;
      is_load_q         <= is_load_d;
      dmem_req_q        <= dmem_req_d;
      dmem_we_q         <= dmem_we_d;
      dmem_addr_q       <= dmem_addr_d;
      dmem_be_q         <= dmem_be_d;
      dmem_wdata_q      <= dmem_wdata_d;
      mem_done_q        <= mem_done_d;
      wb_we_q           <= wb_we_d;
      wb_rd_q           <= wb_rd_d;
      wb_data_q         <= wb_data_d;
      misaligned_q      <= misaligned_d;
      misaligned_addr_q <= misaligned_addr_d;
      bus_err_q         <= bus_err_d;
    end
  end

  assign lsu_stall       = accept_s | (state_q != ST_IDLE);
  assign dmem_req        = dmem_req_q;
  assign dmem_we         = dmem_we_q;
  assign dmem_addr       = dmem_addr_q;
  assign dmem_be         = dmem_be_q;
  assign dmem_wdata      = dmem_wdata_q;
  assign mem_done        = mem_done_q;
  assign wb_we           = wb_we_q;
  assign wb_rd           = wb_rd_q;
  assign wb_data         = wb_data_q;
  assign misaligned      = misaligned_q;
  assign misaligned_addr = misaligned_addr_q;
  assign bus_err         = bus_err_q;

endmodule
